// File: rtl/matrix_multiplier.sv
// 2x2 unsigned matrix multiplier C = A x B; one C element is produced per cycle after a load.
// Optional macro MATMUL_SATURATE_EN clamps overflowing element sums instead of wrapping them.
module matrix_multiplier #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned RES_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DATA_W-1:0]   nums_a,
    input  logic [4*DATA_W-1:0]   nums_b,
    output logic [4*DATA_W-1:0]   loaded_num_a,
    output logic [4*DATA_W-1:0]   loaded_num_b,
    output logic [4*RES_W-1:0]    result,
    output logic                  busy,
    output logic                  multiplication_done
);

    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam int unsigned SUM_W  = 2 * DATA_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMPUTE,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_busy;
    logic                  r_done;
    logic                  w_busy_nxt;
    logic                  w_done_nxt;
    logic                  w_capture;
    logic                  w_step;

    logic [4*DATA_W-1:0]   r_a;
    logic [4*DATA_W-1:0]   r_b;
    logic [RES_W-1:0]      r_c [4];
    logic [1:0]            r_idx;

    logic [DATA_W-1:0]     w_a1;
    logic [DATA_W-1:0]     w_a2;
    logic [DATA_W-1:0]     w_b1;
    logic [DATA_W-1:0]     w_b2;
    logic [PROD_W-1:0]     w_p1;
    logic [PROD_W-1:0]     w_p2;
    logic [SUM_W-1:0]      w_sum;
    logic [RES_W-1:0]      w_elem;

    // Element k of a row-major packed matrix, element 0 in the MSBs.
    function automatic logic [DATA_W-1:0] f_elem(input logic [4*DATA_W-1:0] m, input logic [1:0] k);
        return m[DATA_W*(3-int'(k)) +: DATA_W];
    endfunction

    // State register with the registered status outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Next-state logic: any sampled load restarts the job, even mid-compute.
    always_comb begin
        w_state_nxt = r_state;
        w_busy_nxt  = r_busy;
        w_done_nxt  = r_done;
        w_capture   = 1'b0;
        w_step      = 1'b0;
        if (load) begin
            w_capture   = 1'b1;
            w_state_nxt = S_COMPUTE;
            w_busy_nxt  = 1'b1;
            w_done_nxt  = 1'b0;
        end else begin
            case (r_state)
                S_COMPUTE: begin
                    w_step = 1'b1;
                    if (r_idx == 2'd3) begin
                        w_state_nxt = S_DONE;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Cij = Ai1*B1j + Ai2*B2j with i = idx[1], j = idx[0], taken from the captured operands.
    always_comb begin
        w_a1  = f_elem(r_a, {r_idx[1], 1'b0});
        w_a2  = f_elem(r_a, {r_idx[1], 1'b1});
        w_b1  = f_elem(r_b, {1'b0, r_idx[0]});
        w_b2  = f_elem(r_b, {1'b1, r_idx[0]});
        w_p1  = PROD_W'(w_a1) * PROD_W'(w_b1);
        w_p2  = PROD_W'(w_a2) * PROD_W'(w_b2);
        w_sum = SUM_W'(w_p1) + SUM_W'(w_p2);
`ifdef MATMUL_SATURATE_EN
        w_elem = (w_sum > SUM_W'({RES_W{1'b1}})) ? {RES_W{1'b1}} : RES_W'(w_sum);
`else
        w_elem = RES_W'(w_sum);
`endif
    end

    // Operand capture and result accumulation.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_idx <= '0;
            for (int k = 0; k < 4; k++) r_c[k] <= '0;
        end else if (w_capture) begin
            r_a   <= nums_a;
            r_b   <= nums_b;
            r_idx <= '0;
            for (int k = 0; k < 4; k++) r_c[k] <= '0;
        end else if (w_step) begin
            r_c[r_idx] <= w_elem;
            r_idx      <= r_idx + 2'd1;
        end
    end

    assign loaded_num_a        = r_a;
    assign loaded_num_b        = r_b;
    assign result              = {r_c[0], r_c[1], r_c[2], r_c[3]};
    assign busy                = r_busy;
    assign multiplication_done = r_done;

endmodule

// File: tb/tb_matrix_multiplier.sv
// Scoreboard bench for matrix_multiplier: expected products are queued at load and compared at done.
module tb_matrix_multiplier;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned RES_W  = 16;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] res;
    } job_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [31:0] nums_a;
    logic [31:0] nums_b;
    logic [31:0] loaded_num_a;
    logic [31:0] loaded_num_b;
    logic [63:0] result;
    logic        busy;
    logic        multiplication_done;

    job_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    matrix_multiplier #(.DATA_W(DATA_W), .RES_W(RES_W)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .load                (load),
        .nums_a              (nums_a),
        .nums_b              (nums_b),
        .loaded_num_a        (loaded_num_a),
        .loaded_num_b        (loaded_num_b),
        .result              (result),
        .busy                (busy),
        .multiplication_done (multiplication_done)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int unsigned el(input logic [31:0] m, input int k);
        logic [31:0] t;
        t = m >> (8 * (3 - k));
        return int'(t[7:0]);
    endfunction

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
        logic [63:0]  r;
        int unsigned  s;
        logic [31:0]  s32;
        r = '0;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                s   = el(a, 2*i) * el(b, j) + el(a, 2*i+1) * el(b, 2+j);
                s32 = s;
`ifdef MATMUL_SATURATE_EN
                if (s > 65535) s32 = 32'h0000_FFFF;
`endif
                r[16*(3-(2*i+j)) +: 16] = s32[15:0];
            end
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive a one-cycle load and queue its expected product.
    task automatic do_load(input logic [31:0] a, input logic [31:0] b);
        job_t j;
        nums_a = a;
        nums_b = b;
        load   = 1'b1;
        j.a    = a;
        j.b    = b;
        j.res  = model(a, b);
        sb.push_back(j);
        step();
        load   = 1'b0;
    endtask

    // Wait (bounded) for done, then pop and compare against the scoreboard.
    task automatic wait_and_compare(input string tag, input int exp_edges);
        int   edges;
        job_t j;
        edges = 0;
        while (!multiplication_done && edges < 20) begin
            step();
            edges++;
        end
        check({tag, "_done"}, 64'(multiplication_done), 64'd1);
        if (exp_edges >= 0) check({tag, "_latency"}, 64'(edges), 64'(exp_edges));
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 64'd0, 64'd1);
        end else begin
            j = sb.pop_front();
            check({tag, "_result"}, result, j.res);
            check({tag, "_ld_a"}, 64'(loaded_num_a), 64'(j.a));
            check({tag, "_ld_b"}, 64'(loaded_num_b), 64'(j.b));
        end
    endtask

    initial begin
        logic [63:0] part;
        logic [63:0] full;
        logic [31:0] ra;
        logic [31:0] rb;

        // Reset dominates a held load.
        rst    = 1'b0;
        load   = 1'b1;
        nums_a = 32'hDEAD_BEEF;
        nums_b = 32'h1234_5678;
        step();
        step();
        check("rst_ld_a",   64'(loaded_num_a), 64'd0);
        check("rst_ld_b",   64'(loaded_num_b), 64'd0);
        check("rst_result", result, 64'd0);
        check("rst_busy",   64'(busy), 64'd0);
        check("rst_done",   64'(multiplication_done), 64'd0);
        rst  = 1'b1;
        load = 1'b0;
        step();

        // Basic multiply with per-edge element progression.
        do_load(32'h0102_0408, 32'h0103_050B);
        check("basic_ld_a", 64'(loaded_num_a), 64'h0102_0408);
        check("basic_ld_b", 64'(loaded_num_b), 64'h0103_050B);
        check("basic_busy0", 64'(busy), 64'd1);
        check("basic_res0", result, 64'd0);
        full = {16'd11, 16'd25, 16'd44, 16'd100};
        for (int e = 1; e <= 4; e++) begin
            step();
            part = '0;
            for (int k = 0; k < e; k++) part[16*(3-k) +: 16] = full[16*(3-k) +: 16];
            check($sformatf("basic_res_e%0d", e), result, part);
            check($sformatf("basic_done_e%0d", e), 64'(multiplication_done), 64'(e == 4));
            check($sformatf("basic_busy_e%0d", e), 64'(busy), 64'(e < 4));
        end
        wait_and_compare("basic", 0);

        // Overflow of every element sum.
        do_load(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_and_compare("ovf", 4);
`ifdef MATMUL_SATURATE_EN
        check("ovf_c11", 64'(result[63:48]), 64'h0000_FFFF);
`else
        check("ovf_c11", 64'(result[63:48]), 64'h0000_FC02);
`endif

        // Restart mid-compute: the first job is abandoned.
        do_load(32'h0102_0408, 32'h0103_050B);
        step();
        check("rst_job_busy", 64'(busy), 64'd1);
        void'(sb.pop_back());
        do_load(32'h0100_0001, 32'h0908_0706);
        check("restart_res_clr", result, 64'd0);
        for (int e = 1; e <= 4; e++) begin
            step();
            check($sformatf("restart_done_e%0d", e), 64'(multiplication_done), 64'(e == 4));
        end
        check("restart_const", result, {16'd9, 16'd8, 16'd7, 16'd6});
        wait_and_compare("restart", 0);

        // Reset on the second compute edge, then a clean job.
        do_load(32'h0506_0708, 32'h0102_0304);
        step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        void'(sb.pop_back());
        check("midrst_result", result, 64'd0);
        check("midrst_ld_a",   64'(loaded_num_a), 64'd0);
        check("midrst_busy",   64'(busy), 64'd0);
        check("midrst_done",   64'(multiplication_done), 64'd0);
        step();
        check("midrst_idle",   64'(busy), 64'd0);
        do_load(32'h0304_0506, 32'h0708_090A);
        wait_and_compare("post_rst", 4);

        // Hold: inputs wiggle without load.
        full = result;
        for (int c = 0; c < 10; c++) begin
            nums_a = $urandom;
            nums_b = $urandom;
            step();
            check("hold_result", result, full);
            check("hold_ld_a", 64'(loaded_num_a), 64'h0304_0506);
            check("hold_ld_b", 64'(loaded_num_b), 64'h0708_090A);
            check("hold_done", 64'(multiplication_done), 64'd1);
        end

        // Random jobs, including one accepted the edge after done.
        for (int t = 0; t < 6; t++) begin
            ra = $urandom;
            rb = $urandom;
            do_load(ra, rb);
            wait_and_compare($sformatf("rand%0d", t), 4);
        end

        // Held load restarts every edge; done follows the last high sample.
        nums_a = 32'h0203_0405;
        nums_b = 32'h0607_0809;
        load   = 1'b1;
        step();
        step();
        step();
        load   = 1'b0;
        begin
            job_t j;
            j.a   = nums_a;
            j.b   = nums_b;
            j.res = model(nums_a, nums_b);
            sb.push_back(j);
        end
        check("held_busy", 64'(busy), 64'd1);
        wait_and_compare("held", 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
